// File: rtl/gf2m_pkg.sv
// Shared GF(2^M) constants, FSM encoding and the carry-less helpers used by
// both the digit-serial datapath and any reference model.
package gf2m_pkg;

   localparam int          M    = 93;
   localparam int          D    = 6;
   localparam logic [92:0] POLY = 93'h5;
   localparam int          NDIG = (M + D - 1) / D;

   // Working width of the helpers; any instance must satisfy M + D <= MAXW.
   localparam int MAXW = 128;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [MAXW-1:0] clmul_md(input logic [MAXW-1:0] a,
                                                input logic [MAXW-1:0] dig,
                                                input int              d);
      logic [MAXW-1:0] p;
      p = '0;
      for (int j = 0; j < MAXW; j++)
         if (j < d && dig[j]) p = p ^ (a << j);
      return p;
   endfunction

   function automatic logic [MAXW-1:0] reduce_md(input logic [MAXW-1:0] t,
                                                 input int              m,
                                                 input int              d,
                                                 input logic [MAXW-1:0] poly);
      logic [MAXW-1:0] r;
      r = t;
      for (int i = MAXW - 1; i >= 0; i--)
         if (i >= m && i < m + d && r[i]) begin
            r    = r ^ (poly << (i - m));
            r[i] = 1'b0;
         end
      return r;
   endfunction

endpackage

// File: rtl/gf2m_digit_serial_mult_step.sv
// One digit step: next_acc = reduce((acc << D) ^ clmul(a, dig)).
module gf2m_digit_step #(
   parameter int             M    = 93,
   parameter int             D    = 6,
   parameter logic [M-1:0]   POLY = 93'h5
) (
   input  logic [M-1:0] acc,
   input  logic [M-1:0] a_reg,
   input  logic [D-1:0] dig,
   output logic [M-1:0] acc_nxt
);
   import gf2m_pkg::*;

   logic [MAXW-1:0] t;
   logic [MAXW-1:0] r;

   always_comb begin
      t       = (MAXW'(acc) << D) ^ clmul_md(MAXW'(a_reg), MAXW'(dig), D);
      r       = reduce_md(t, M, D, MAXW'(POLY));
      acc_nxt = r[M-1:0];
   end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier: MSB digit of b first, one digit per cycle,
// valid/ready on both sides, result held in DONE until taken.
module gf2m_digit_serial_mult #(
   parameter int           M    = gf2m_pkg::M,
   parameter int           D    = gf2m_pkg::D,
   parameter logic [M-1:0] POLY = M'(gf2m_pkg::POLY)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] y,
   output logic         busy
);
   import gf2m_pkg::*;

   localparam int ND = (M + D - 1) / D;
   localparam int BW = ND * D;
   localparam int CW = (ND > 1) ? $clog2(ND) : 1;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [M-1:0]    a_q, acc_q, y_q, acc_nxt;
   logic [BW-1:0]   b_q;
   logic [D-1:0]    dig;
   logic            load, step;

   assign dig = b_q[cnt_q*D +: D];

   gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step (
      .acc     (acc_q),
      .a_reg   (a_q),
      .dig     (dig),
      .acc_nxt (acc_nxt)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: if (in_valid) begin
            load    = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            a_q   <= a;
            b_q   <= BW'(b);   // zero digits above M fold in as nothing
            acc_q <= '0;
            cnt_q <= CW'(ND - 1);
         end
         if (step) begin
            acc_q <= acc_nxt;
            if (cnt_q == '0) y_q <= acc_nxt;
            else             cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign y         = y_q;

endmodule
